// File: rtl/exe_mem_pkg.sv
// Shared constants for the EXE->MEM pipeline register: control-bundle bit
// positions and default field widths.
package exe_mem_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned REG_W_DEFAULT  = 5;
    localparam int unsigned CTRL_W         = 9;

    localparam int unsigned MEMREAD_BIT     = 0;
    localparam int unsigned MEMWRITE_BIT    = 1;
    localparam int unsigned MEMTOREG_BIT    = 2;
    localparam int unsigned REGWRITE_BIT    = 3;
    localparam int unsigned READFROMMEM_BIT = 4;
    localparam int unsigned WRITETOMEM_BIT  = 5;
    localparam int unsigned R_MEMTOREG_BIT  = 6;
    localparam int unsigned BYTE_BIT        = 7;
    localparam int unsigned JAL_BIT         = 8;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline slot: a valid flag plus payload register. The payload only
// loads on capture so idle cycles do not toggle the data flops.
module pipe_skid_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // clear wins over load so a flush always empties the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load && !clear) begin
            data_q <= d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// Elastic EXE->MEM pipeline register: main entry drives MEM, a skid entry
// absorbs one extra instruction so in_ready never depends on out_ready.
module exe_mem_stage_reg #(
    parameter int unsigned DATA_W       = exe_mem_pkg::DATA_W_DEFAULT,
    parameter int unsigned REG_W        = exe_mem_pkg::REG_W_DEFAULT,
    parameter int unsigned CTRL_W       = exe_mem_pkg::CTRL_W,
    parameter int unsigned REGWRITE_BIT = exe_mem_pkg::REGWRITE_BIT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_treg,
    input  logic [REG_W-1:0]  in_dst,
    input  logic [REG_W-1:0]  in_fp_dst,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_treg,
    output logic [REG_W-1:0]  out_dst,
    output logic [REG_W-1:0]  out_fp_dst,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dst,
    output logic [CNT_W-1:0]  stall_cnt
);

    import exe_mem_pkg::*;

    localparam int unsigned PW = 2 * DATA_W + 2 * REG_W + CTRL_W;

    logic          main_v, skid_v;
    logic [PW-1:0] main_pl, skid_pl, in_pl, main_d;
    logic          acc, drn;
    logic          main_load, main_clear, skid_load, skid_clear;
    logic [CNT_W-1:0] stall_q;

    assign in_pl = {in_result, in_treg, in_dst, in_fp_dst, in_ctrl};

    assign in_ready = !skid_v;
    assign acc      = in_valid && in_ready && !flush;
    assign drn      = main_v && out_ready;

    // skid is only ever full while main is full, so an empty main takes input
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_v ? skid_pl : in_pl;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_v) begin
            main_load = acc;
        end else if (drn) begin
            if (skid_v) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (acc) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else begin
            skid_load = acc;
        end
    end

    pipe_skid_entry #(
        .W (PW)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_pl)
    );

    pipe_skid_entry #(
        .W (PW)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_pl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!flush && main_v && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign {out_result, out_treg, out_dst, out_fp_dst, out_ctrl} = main_pl;

    assign out_valid = main_v;
    assign fwd_valid = main_v && main_pl[REGWRITE_BIT];
    assign fwd_dst   = out_dst;
    assign stall_cnt = stall_q;

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Parametrised, elastic EXE→MEM pipeline register.
- Carries the ALU result, store data, integer/FP destination registers and a generic control bundle.
- Adds a valid/ready handshake with a one-entry skid buffer, a synchronous flush, a forwarding tap and a saturating stall counter.
- Sits between the execute stage and the data-memory stage; lets MEM back-pressure EXE without combinational ready paths.

Parameters:
- DATA_W, 64, width of result and store-data fields
- REG_W, 5, width of integer and FP destination register indices
- CTRL_W, 9, width of the control bundle (MemRead, MemWrite, MemtoReg, RegWrite, ReadfromMem, WritetoMem, R_memtoReg, Byte, JmpandLink)
- REGWRITE_BIT, 3, index of RegWrite inside the control bundle
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EXE presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU result / address
- in_treg  in  DATA_W  store data
- in_dst  in  REG_W  integer destination
- in_fp_dst  in  REG_W  FP destination
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  MEM holds a valid instruction
- out_ready  in  1  MEM consumes this cycle
- out_result  out  DATA_W  registered result
- out_treg  out  DATA_W  registered store data
- out_dst  out  REG_W  registered integer destination
- out_fp_dst  out  REG_W  registered FP destination
- out_ctrl  out  CTRL_W  registered control bundle
- fwd_valid  out  1  out_valid AND out_ctrl[REGWRITE_BIT]
- fwd_dst  out  REG_W  equals out_dst
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- State: main entry (main_v plus payload), skid entry (skid_v plus payload), stall counter.
- Reset (rst_n=0, asynchronous): main_v=0, skid_v=0, all payloads 0, stall_cnt=0. Hence out_valid=0, every out_* is 0, fwd_valid=0, in_ready=1. Reset is honoured mid-transfer; any in-flight instruction is lost.
- in_ready = !skid_v. It is a register output only; no combinational path from out_ready.
- Accept: acc = in_valid & in_ready & !flush.
- Drain: drn = main_v & out_ready.
- Main entry is the output; out_* come directly from main registers. Latency is 1 cycle when unstalled.
- Transitions per rising edge when flush=0:
  - main empty, acc: main ← input.
  - main full, drn, skid empty, acc: main ← input.
  - main full, drn, skid full: main ← skid, skid_v ← 0. acc is impossible because in_ready=0.
  - main full, !drn, acc: skid ← input, skid_v ← 1.
  - main full, drn, no acc, skid empty: main_v ← 0.
  - otherwise hold.
- Ordering is strictly FIFO; the skid entry never overtakes main.
- flush=1: main_v ← 0 and skid_v ← 0 next edge. Input is discarded even if in_valid=1. Payload registers may keep stale data, but fwd_valid must be 0. flush has priority over acc and drn; an out_ready handshake in the same cycle still counts as consumed by MEM.
- Payload registers load only on capture, not every cycle. This keeps switching low.
- stall_cnt: increments when out_valid & !out_ready and flush=0. Saturates at all-ones with no wrap. Cleared only by reset.
- Throughput is one instruction per cycle with out_ready held at 1.

Decomposition:
- Shared package exe_mem_pkg holds:
  - ctrl bit-index constants (MEMREAD_BIT … JAL_BIT, REGWRITE_BIT)
  - CTRL_W
  - the default DATA_W/REG_W
- One sub-module is natural: pipe_skid_entry, a payload+valid register with load/clear enables, instantiated twice.
- Counter and control logic live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_valid=1 → out_valid, out_result, stall_cnt all 0 immediately; in_ready=1.
- Streaming: out_ready=1; present results 0x10, 0x20, 0x30 on consecutive cycles → out_result is 0x10, 0x20, 0x30 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure: hold 0x10 in main; out_ready=0; send 0x20 → skid captures 0x20 and in_ready=0 next cycle. Keep out_ready=0 for 3 cycles → stall_cnt=4 and 0x30 is held upstream. Set out_ready=1 → sequence 0x10, 0x20, 0x30 with no loss or duplication.
- Flush: main=0x10, skid=0x20, flush=1 with in_valid=1 (0x30) → next cycle out_valid=0, in_ready=1, fwd_valid=0; 0x30 never appears.
- Forwarding: in_ctrl with RegWrite=1, in_dst=7 → fwd_valid=1 and fwd_dst=7 while held. Same with RegWrite=0 → fwd_valid=0.
- Saturation: CNT_W=4; stall 20 cycles → stall_cnt=15 and stays 15.
